// File: rtl/axis_wormhole_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_wormhole_rr_arbiter
//
// Shares one outgoing AXI-Stream channel among N_INPUTS competing input
// ports of a mesh router. Arbitration is round-robin and packet-locked
// (wormhole): the granted input owns the output until its TLAST flit
// handshakes, so flits of different packets never interleave.
//
// An idle arbiter spends one cycle choosing an owner; no flit moves in
// that cycle. While locked, the data path and the TREADY return path are
// purely combinational, so each flit costs no extra latency.
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous reset, active-high
//   req_i         per-input "head flit is routed here" (looked at only in IDLE)
//   in_tvalid_i   per-input TVALID
//   in_tready_o   per-input TREADY (only the owner's bit can be set)
//   in_tdata_i    per-input TDATA, input k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_tlast_i    per-input TLAST
//   out_tvalid_o  output TVALID (mirrors the owner)
//   out_tready_i  output TREADY
//   out_tdata_o   output TDATA (zero when idle)
//   out_tlast_o   output TLAST (zero when idle)
//   grant_o       one-hot current owner, all-zero in IDLE
//   busy_o        high while a packet holds the lock
// ---------------------------------------------------------------------------
module axis_wormhole_rr_arbiter #(
  parameter int N_INPUTS   = 5,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(N_INPUTS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_INPUTS-1:0]            req_i,
  input  logic [N_INPUTS-1:0]            in_tvalid_i,
  output logic [N_INPUTS-1:0]            in_tready_o,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_tdata_i,
  input  logic [N_INPUTS-1:0]            in_tlast_i,
  output logic                           out_tvalid_o,
  input  logic                           out_tready_i,
  output logic [DATA_WIDTH-1:0]          out_tdata_o,
  output logic                           out_tlast_o,
  output logic [N_INPUTS-1:0]            grant_o,
  output logic                           busy_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Increment an input index modulo N_INPUTS; correct for any N_INPUTS,
  // not only powers of two.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] v);
    if (v == IDX_WIDTH'(N_INPUTS - 1)) begin
      return '0;
    end else begin
      return v + IDX_WIDTH'(1);
    end
  endfunction

  logic [0:0]            state_r;
  logic [IDX_WIDTH-1:0]  grant_q_r;
  logic [IDX_WIDTH-1:0]  rr_ptr_r;

  logic [N_INPUTS-1:0]   cand_s;
  logic                  sel_found_s;
  logic [IDX_WIDTH-1:0]  sel_idx_s;
  logic [IDX_WIDTH-1:0]  probe_s;
  logic                  locked_s;
  logic [N_INPUTS-1:0]   grant_s;
  logic                  out_tvalid_s;
  logic                  out_tlast_s;
  logic [DATA_WIDTH-1:0] out_tdata_s;
  logic                  release_s;

  // Round-robin pick: walk the candidates starting at rr_ptr_r with wrap,
  // and keep the first one found.
  always_comb begin
    cand_s      = req_i & in_tvalid_i;
    sel_found_s = 1'b0;
    sel_idx_s   = rr_ptr_r;
    probe_s     = rr_ptr_r;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (!sel_found_s && cand_s[probe_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = probe_s;
      end else begin
        // keep the earlier pick (or keep searching)
      end
      probe_s = wrap_inc(probe_s);
    end
  end

  // One-hot owner decode, qualified by the lock so IDLE drives all zeros.
  always_comb begin
    locked_s = (state_r == ST_LOCKED);
    for (int i = 0; i < N_INPUTS; i++) begin
      grant_s[i] = locked_s && (grant_q_r == IDX_WIDTH'(i));
    end
  end

  // Owner mux as an AND-OR over the one-hot grant: no owner means all
  // outputs read zero, which gives the idle/reset values for free.
  always_comb begin
    out_tdata_s = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_s[i]) begin
        out_tdata_s = in_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        // not the owner, contributes nothing
      end
    end
    out_tvalid_s = |(grant_s & in_tvalid_i);
    out_tlast_s  = |(grant_s & in_tlast_i);
    release_s    = out_tvalid_s && out_tready_i && out_tlast_s;
  end

  // Drive the ports; only the owner ever sees out_tready_i.
  always_comb begin
    in_tready_o  = grant_s & {N_INPUTS{out_tready_i}};
    out_tvalid_o = out_tvalid_s;
    out_tdata_o  = out_tdata_s;
    out_tlast_o  = out_tlast_s;
    grant_o      = grant_s;
    busy_o       = locked_s;
  end

  // Lock state machine: IDLE picks an owner, LOCKED holds it until the
  // TLAST handshake, which also moves the pointer past the owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      grant_q_r <= '0;
      rr_ptr_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s) begin
            state_r   <= ST_LOCKED;
            grant_q_r <= sel_idx_s;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (release_s) begin
            state_r   <= ST_IDLE;
            grant_q_r <= '0;
            rr_ptr_r  <= wrap_inc(grant_q_r);
          end else begin
            state_r   <= ST_LOCKED;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          grant_q_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_wormhole_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_wormhole_rr_arbiter
//
// Directed bench for axis_wormhole_rr_arbiter (N_INPUTS=5, DATA_WIDTH=32).
// Inputs change 1 time unit after the rising edge; outputs are looked at on
// the falling edge. Expected values are written out by hand per scenario.
// ---------------------------------------------------------------------------
module tb_axis_wormhole_rr_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  in_tvalid;
  logic [N-1:0]  in_tready;
  logic [N*DW-1:0] in_tdata;
  logic [N-1:0]  in_tlast;
  logic          out_tvalid;
  logic          out_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tlast;
  logic [N-1:0]  grant;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_wormhole_rr_arbiter #(
    .N_INPUTS   (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .in_tvalid_i  (in_tvalid),
    .in_tready_o  (in_tready),
    .in_tdata_i   (in_tdata),
    .in_tlast_i   (in_tlast),
    .out_tvalid_o (out_tvalid),
    .out_tready_i (out_tready),
    .out_tdata_o  (out_tdata),
    .out_tlast_o  (out_tlast),
    .grant_o      (grant),
    .busy_o       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // grant, busy (implied by grant), out_tvalid and in_tready in one go
  task automatic check_state(input string tag, input logic [N-1:0] g,
                             input logic v, input logic [N-1:0] r);
    check_val({tag, ".grant"}, 32'(grant), 32'(g));
    check_val({tag, ".busy"}, 32'(busy), 32'(g != 5'b00000));
    check_val({tag, ".tvalid"}, 32'(out_tvalid), 32'(v));
    check_val({tag, ".tready"}, 32'(in_tready), 32'(r));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_flit(input int k, input logic [31:0] d, input logic l);
    in_tdata[k*DW +: DW] = d;
    in_tlast[k]          = l;
  endtask

  task automatic clear_inputs();
    req        = 5'b00000;
    in_tvalid  = 5'b00000;
    in_tlast   = 5'b00000;
    in_tdata   = '0;
    out_tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] e;
    int pat [8];
    int sent;
    int rx;

    // ---------------- reset values ----------------
    rst = 1'b1;
    clear_inputs();
    step();
    sample();
    check_state("rst", 5'b00000, 1'b0, 5'b00000);
    check_val("rst.tdata", out_tdata, 32'h0);
    check_val("rst.tlast", 32'(out_tlast), 32'h0);
    step();
    rst = 1'b0;

    // ---------------- t1: full round of single-flit packets ----------------
    req       = 5'b11111;
    in_tvalid = 5'b11111;
    for (int k = 0; k < N; k++) set_flit(k, 32'h10 + 32'(k), 1'b1);
    for (int k = 0; k < 6; k++) begin
      sample();
      check_state("t1.idle", 5'b00000, 1'b0, 5'b00000);
      step();
      sample();
      e = 5'(1 << (k % N));
      check_state("t1.lock", e, 1'b1, e);
      check_val("t1.tdata", out_tdata, 32'h10 + 32'(k % N));
      check_val("t1.tlast", 32'(out_tlast), 32'h1);
      step();
    end

    // ---------------- t2: 4-flit packet from input 2, input 0 waits ----------------
    do_reset();
    req       = 5'b00100;
    in_tvalid = 5'b00100;
    set_flit(2, 32'hA0, 1'b0);
    sample();
    check_state("t2.idle", 5'b00000, 1'b0, 5'b00000);
    step();
    req[0]       = 1'b1;
    in_tvalid[0] = 1'b1;
    set_flit(0, 32'h55, 1'b1);
    for (int f = 0; f < 4; f++) begin
      set_flit(2, 32'hA0 + 32'(f), f == 3);
      sample();
      check_state("t2.flit", 5'b00100, 1'b1, 5'b00100);
      check_val("t2.tdata", out_tdata, 32'hA0 + 32'(f));
      check_val("t2.tlast", 32'(out_tlast), 32'(f == 3));
      step();
    end
    req[2]       = 1'b0;
    in_tvalid[2] = 1'b0;
    sample();
    check_state("t2.gap", 5'b00000, 1'b0, 5'b00000);
    step();
    sample();
    check_state("t2.in0", 5'b00001, 1'b1, 5'b00001);
    check_val("t2.in0.tdata", out_tdata, 32'h55);
    step();

    // ---------------- t3: owner 3 with output stalls ----------------
    do_reset();
    req       = 5'b01000;
    in_tvalid = 5'b01000;
    set_flit(3, 32'hB0, 1'b0);
    sample();
    check_state("t3.idle", 5'b00000, 1'b0, 5'b00000);
    step();
    pat  = '{1, 0, 0, 1, 1, 1, 1, 1};
    sent = 0;
    rx   = 0;
    for (int c = 0; c < 8 && sent < 3; c++) begin
      out_tready = (pat[c] != 0);
      set_flit(3, 32'hB0 + 32'(sent), sent == 2);
      sample();
      check_val("t3.tdata", out_tdata, 32'hB0 + 32'(sent));
      check_val("t3.tlast", 32'(out_tlast), 32'(sent == 2));
      check_state("t3.lock", 5'b01000, 1'b1, (pat[c] != 0) ? 5'b01000 : 5'b00000);
      if (out_tvalid && out_tready) rx++;
      if (pat[c] != 0) sent++;
      step();
    end
    check_val("t3.rx_count", 32'(rx), 32'd3);
    in_tvalid  = 5'b00000;
    req        = 5'b00000;
    out_tready = 1'b1;
    sample();
    check_state("t3.done", 5'b00000, 1'b0, 5'b00000);

    // ---------------- t4: pointer wrap after input 4 ----------------
    do_reset();
    req       = 5'b10000;
    in_tvalid = 5'b10000;
    set_flit(4, 32'hC4, 1'b1);
    step();
    sample();
    check_state("t4.in4a", 5'b10000, 1'b1, 5'b10000);
    req       = 5'b10010;
    in_tvalid = 5'b10010;
    set_flit(1, 32'hC1, 1'b1);
    step();
    sample();
    check_state("t4.idle1", 5'b00000, 1'b0, 5'b00000);
    step();
    sample();
    check_state("t4.in1", 5'b00010, 1'b1, 5'b00010);
    check_val("t4.in1.tdata", out_tdata, 32'hC1);
    step();
    req[1]       = 1'b0;
    in_tvalid[1] = 1'b0;
    step();
    sample();
    check_state("t4.in4b", 5'b10000, 1'b1, 5'b10000);
    check_val("t4.in4b.tdata", out_tdata, 32'hC4);
    step();

    // ---------------- t5: owner gaps its TVALID mid-packet ----------------
    do_reset();
    req       = 5'b00010;
    in_tvalid = 5'b00010;
    set_flit(1, 32'hD0, 1'b0);
    step();
    sample();
    check_state("t5.f0", 5'b00010, 1'b1, 5'b00010);
    check_val("t5.f0.tdata", out_tdata, 32'hD0);
    step();
    req       = 5'b00000;
    in_tvalid = 5'b00000;
    for (int c = 0; c < 3; c++) begin
      sample();
      check_state("t5.gap", 5'b00010, 1'b0, 5'b00010);
      step();
    end
    in_tvalid = 5'b00010;
    set_flit(1, 32'hD1, 1'b1);
    sample();
    check_state("t5.f1", 5'b00010, 1'b1, 5'b00010);
    check_val("t5.f1.tdata", out_tdata, 32'hD1);
    check_val("t5.f1.tlast", 32'(out_tlast), 32'h1);
    step();
    in_tvalid = 5'b00000;
    sample();
    check_state("t5.done", 5'b00000, 1'b0, 5'b00000);

    // ---------------- t6: reset in the middle of a packet ----------------
    do_reset();
    req       = 5'b00100;
    in_tvalid = 5'b00100;
    set_flit(2, 32'hE2, 1'b1);
    step();
    sample();
    check_state("t6.in2", 5'b00100, 1'b1, 5'b00100);
    step();
    req       = 5'b01000;
    in_tvalid = 5'b01000;
    set_flit(3, 32'hF0, 1'b0);
    step();
    sample();
    check_state("t6.f0", 5'b01000, 1'b1, 5'b01000);
    step();
    set_flit(3, 32'hF1, 1'b0);
    rst = 1'b1;
    sample();
    check_state("t6.f1", 5'b01000, 1'b1, 5'b01000);
    check_val("t6.f1.tdata", out_tdata, 32'hF1);
    step();
    sample();
    check_state("t6.rst", 5'b00000, 1'b0, 5'b00000);
    check_val("t6.rst.tdata", out_tdata, 32'h0);
    rst       = 1'b0;
    req       = 5'b01001;
    in_tvalid = 5'b01001;
    set_flit(0, 32'hE0, 1'b1);
    set_flit(3, 32'hF3, 1'b1);
    step();
    sample();
    check_state("t6.restart", 5'b00001, 1'b1, 5'b00001);
    check_val("t6.restart.tdata", out_tdata, 32'hE0);
    step();
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_wormhole_rr_arbiter.md
Name: axis_wormhole_rr_arbiter

Overview:
- Per-output-port arbiter for the dual (REQ/RESP) XY mesh router. It shares one outgoing AXI-Stream channel among N input ports (HOME, NORTH, EAST, SOUTH, WEST).
- Packet-locked (wormhole) round-robin: once an input is granted, it owns the output until its TLAST flit handshakes. This prevents flit interleaving of AW/W/B/AR/R packets.
- The router instantiates one arbiter per output direction per network (REQ and RESP), i.e. 10 per router. XY route computation is external and arrives as req_i.

Parameters:
- N_INPUTS, 5, number of competing input ports (N_INPUTS >= 2).
- DATA_WIDTH, 32, TDATA width in bits (equals the mesh AXIS_DATA_WIDTH).
- IDX_WIDTH, $clog2(N_INPUTS), width of the grant index and round-robin pointer.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  N_INPUTS  bit k = input k's head flit is routed to this output; sampled only in IDLE.
- in_tvalid_i  in  N_INPUTS  per-input TVALID.
- in_tready_o  out  N_INPUTS  per-input TREADY.
- in_tdata_i  in  N_INPUTS*DATA_WIDTH  per-input TDATA; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_tlast_i  in  N_INPUTS  per-input TLAST.
- out_tvalid_o  out  1  output TVALID.
- out_tready_i  in  1  output TREADY.
- out_tdata_o  out  DATA_WIDTH  output TDATA.
- out_tlast_o  out  1  output TLAST.
- grant_o  out  N_INPUTS  one-hot current owner; all-zero in IDLE.
- busy_o  out  1  1 while in LOCKED.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, rr_ptr=0, grant=0.
  - Outputs while and after reset until the next grant: out_tvalid_o=0, in_tready_o=0, grant_o=0, busy_o=0, out_tdata_o=0, out_tlast_o=0.
- State IDLE:
  - cand = req_i & in_tvalid_i.
  - If cand != 0, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_INPUTS-1, 0, ..., rr_ptr-1).
  - Next edge: grant_q = selected index, state=LOCKED.
  - In IDLE, out_tvalid_o=0 and in_tready_o=0. Cost: 1 arbitration cycle per packet, no flit transferred in that cycle.
- State LOCKED, owner g:
  - out_tvalid_o=in_tvalid_i[g], out_tdata_o=in_tdata_i[g], out_tlast_o=in_tlast_i[g].
  - in_tready_o[g]=out_tready_i; all other in_tready_o bits are 0. Purely combinational path, zero added latency per flit.
  - req_i is ignored; deassertion mid-packet does not release the lock.
- Release:
  - Handshake (out_tvalid_o & out_tready_i) with out_tlast_o=1 at an edge: state=IDLE, grant cleared, rr_ptr=(g+1) mod N_INPUTS.
  - The wrap must be correct for non-power-of-two N_INPUTS (e.g. g=4, N=5 gives rr_ptr=0).
  - Single-flit packet (TLAST on the head flit) holds exactly one LOCKED cycle if out_tready_i=1.
- Stalls:
  - out_tready_i=0 holds all outputs stable (AXIS rule: TVALID is not dropped by the arbiter once asserted, because it mirrors the owner).
  - An owner deasserting in_tvalid_i mid-packet leaves out_tvalid_o=0 with the lock kept.
- Fairness: a continuously requesting input waits at most N_INPUTS-1 packets.
- Simultaneous events:
  - Requests that become valid during the release cycle are evaluated in the following IDLE cycle using the updated rr_ptr.
  - rst_i has priority over every transition.
  - Reset mid-packet abandons the lock. Upstream is reset by the same reset, so no residual flits are expected.
- Width rules:
  - grant_o = one-hot decode of grant_q, qualified by LOCKED.
  - No arithmetic beyond the modulo increment of IDX_WIDTH.

Test Plan:
- Reset, then all inputs valid with req_i=5'b11111, single-flit packets, out_tready_i=1 → grant_o sequence 00001, 00010, 00100, 01000, 10000, 00001; each grant lasts 1 cycle, separated by 1 IDLE cycle.
- Input 2 sends a 4-flit packet (tdata 0xA0..0xA3, TLAST on the 4th) while input 0 requests from cycle 1 → output emits 0xA0..0xA3 contiguously from input 2 only; input 0 is granted only after the 0xA3 handshake; in_tready_o[0]=0 throughout.
- Owner input 3 with out_tready_i toggling 1,0,0,1 mid-packet → out_tdata_o and out_tlast_o stable while stalled; no flit lost or duplicated; the received sequence equals the sent one.
- After input 4 completes a packet (rr_ptr wraps to 0), inputs 4 and 1 both request → input 1 granted first, then input 4.
- Input 1 locked, req_i[1] dropped and in_tvalid_i[1] gapped for 3 cycles mid-packet → busy_o=1 and grant_o=00010 held; out_tvalid_o=0 during the gap; the packet completes afterwards.
- rst_i asserted during flit 2 of a 3-flit packet → next edge: busy_o=0, grant_o=0, in_tready_o=0; after release, arbitration restarts at input 0.
